counter_sequencer: RTL and testbench
====================================

# counter_sequencer

Command-driven controller for the board's 24-bit demo counter and its prescaler. It owns the prescaler and decides when the counter increments or clears. It runs free-running or for an exact burst of N increments, and accepts commands over a valid/ready handshake. It sits between the io_in command decode and the counter register in the user design top level.

## Interface
- PRESCALE_W, 16: prescaler and limit width.
- COUNT_W, 24: burst-length width; also the cmd_arg width.
- DEFAULT_LIMIT, 1000: prescale limit after reset; tick period is limit+1 cycles.

- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command can be accepted; a transfer occurs when cmd_valid && cmd_ready at a rising edge.
- cmd_op  in  2  command: 0 STOP, 1 RUN_FREE, 2 RUN_N, 3 SET_LIMIT.
- cmd_arg  in  COUNT_W  RUN_N burst length, or SET_LIMIT value (low PRESCALE_W bits used, upper bits ignored).
- ctr_inc  out  1  one-cycle increment pulse to the counter.
- ctr_clr  out  1  one-cycle clear pulse to the counter.
- done  out  1  one-cycle pulse when a burst completes.
- busy  out  1  state != IDLE.
- state  out  2  current FSM state, for debug LEDs.

## Operation
- FSM states: IDLE=0, FREE=1, BURST=2.
- Prescaler runs only in FREE/BURST. It counts 0..limit and wraps to 0 when prescale >= limit. A tick is generated when prescale == limit. With limit 0, a tick occurs every cycle.
- cmd_ready is 1 in every state. It is 0 only in the cycle rst is high.
- STOP: go to IDLE from any state and clear the prescaler. A tick due in the accept cycle is suppressed. A STOP received in IDLE is a no-op.
- RUN_FREE: go to FREE and restart the prescaler at 0. No ctr_clr. From BURST, the burst is abandoned without a done pulse.
- RUN_N with arg N>0: go to BURST, restart the prescaler, load remaining=N, and pulse ctr_clr on the cycle after acceptance. A RUN_N received during a burst restarts it.
- RUN_N with arg 0: no state change. done pulses on the cycle after acceptance, with no ctr_clr.
- SET_LIMIT: update limit in any state; state and prescaler are unchanged. The accept cycle compares against the old limit. If prescale > new limit afterwards, the prescaler wraps to 0 on the next cycle without a tick.
- In BURST, each tick decrements remaining. The tick that brings remaining to 0 returns the FSM to IDLE. That tick's ctr_inc and done are asserted together.
- A tick in FREE/BURST in the same cycle as an accepted RUN_* is dropped, because the prescaler restarts.
- remaining is COUNT_W bits wide and never underflows.

## Timing
- Reset values:
  - state=IDLE, prescale=0, limit=DEFAULT_LIMIT, remaining=0.
  - ctr_inc=0, ctr_clr=0, done=0, busy=0.
- All outputs are registered.
- Command accepted at edge E0: prescale=0 after E0, and prescale==limit after E0+limit. The first ctr_inc is high for exactly the cycle following edge E0+limit+1. Subsequent pulses follow every limit+1 cycles.
- ctr_clr is high for the cycle following E0, so it always precedes the first ctr_inc (limit 0 gives ctr_clr after E0 and ctr_inc after E0+1).
- busy and state reflect the new state in the cycle following E0.
- rst asserted mid-burst returns all registers to their reset values at that edge, with no done pulse.

## Structure
- Package counter_pkg holds:
  - op encodings (OP_STOP, OP_RUN_FREE, OP_RUN_N, OP_SET_LIMIT);
  - the state enum (ST_IDLE, ST_FREE, ST_BURST);
  - the default widths and limit.
- One sub-module, counter_tick_gen: prescaler with enable, synchronous restart, limit input and a registered tick output. The FSM, burst counter and handshake stay in counter_sequencer.

## Test plan
- After reset with default limit, issue RUN_FREE at edge E0 -> ctr_inc pulses at E0+1001, E0+2002 and E0+3003; ctr_clr is never asserted; busy=1, state=1.
- SET_LIMIT 3 then RUN_N 5 -> ctr_clr pulses one cycle after acceptance, then exactly 5 ctr_inc pulses 4 cycles apart. done coincides with the 5th pulse, then state=0 and busy=0.
- RUN_N 0 -> done pulses once after one cycle; no ctr_clr, no ctr_inc; state stays 0.
- SET_LIMIT 0 while FREE with prescale=700 (limit 1000) -> prescaler wraps to 0 without a tick, then ctr_inc is asserted every cycle.
- Running with limit 4: STOP accepted in the cycle prescale==4 -> no ctr_inc follows, and state=0 next cycle. Separately, assert rst during a burst with remaining=3 -> no done pulse, all outputs 0, limit back to 1000.
- Hold cmd_valid high continuously with RUN_N 2 at limit 1 -> the burst restarts every cycle, so no ctr_inc and no done ever occur; ctr_clr is high continuously from the cycle after the first acceptance.

Source files
------------

// File: rtl/counter_pkg.sv
// ============================================================
// counter_pkg: shared encodings and defaults for the demo counter sequencer
// Rev 1.0
// ============================================================
`default_nettype none

package counter_pkg;

  localparam int c_prescale_w    = 16;
  localparam int c_count_w       = 24;
  localparam int c_default_limit = 1000;

  localparam logic [1:0] OP_STOP      = 2'd0;
  localparam logic [1:0] OP_RUN_FREE  = 2'd1;
  localparam logic [1:0] OP_RUN_N     = 2'd2;
  localparam logic [1:0] OP_SET_LIMIT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FREE  = 2'd1,
    ST_BURST = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/counter_tick_gen.sv
// ============================================================
// counter_tick_gen: prescaler counting 0..limit with a registered tick
// Rev 1.0
// ============================================================
`default_nettype none

module counter_tick_gen
  import counter_pkg::*;
#(
  parameter int PRESCALE_W = c_prescale_w
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  restart,
  input  logic [PRESCALE_W-1:0] limit,
  output logic                  tick_due,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] r_prescale;
  logic                  r_tick;

  // Raw tick condition; a same-cycle restart suppresses it in the register below.
  assign tick_due = en && (r_prescale == limit);
  assign tick     = r_tick;

  always_ff @(posedge clk) begin
    if (rst || restart || !en) begin
      r_prescale <= '0;
      r_tick     <= 1'b0;
    end else begin
      r_tick <= tick_due;
      // >= so a limit lowered below the current count wraps without a tick
      if (r_prescale >= limit) r_prescale <= '0;
      else                     r_prescale <= r_prescale + PRESCALE_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/counter_sequencer.sv
// ============================================================
// counter_sequencer: command-driven free-run / burst control of the demo counter
// Rev 1.0
// ============================================================
`default_nettype none

module counter_sequencer
  import counter_pkg::*;
#(
  parameter int PRESCALE_W    = c_prescale_w,
  parameter int COUNT_W       = c_count_w,
  parameter int DEFAULT_LIMIT = c_default_limit
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [COUNT_W-1:0] cmd_arg,
  output logic               ctr_inc,
  output logic               ctr_clr,
  output logic               done,
  output logic               busy,
  output logic [1:0]         state
);

  state_t                r_state, w_state_n;
  logic [COUNT_W-1:0]    r_remaining, w_remaining_n;
  logic [PRESCALE_W-1:0] r_limit, w_limit_n;
  logic                  r_clr, w_clr_n;
  logic                  r_done, w_done_n;
  logic                  r_busy;
  logic                  w_accept, w_restart, w_tick_due;

  assign cmd_ready = ~rst;
  assign w_accept  = cmd_valid & cmd_ready;

  counter_tick_gen #(
    .PRESCALE_W (PRESCALE_W)
  ) u_tick (
    .clk      (clk),
    .rst      (rst),
    .en       (r_state != ST_IDLE),
    .restart  (w_restart),
    .limit    (r_limit),
    .tick_due (w_tick_due),
    .tick     (ctr_inc)
  );

  always_comb begin
    w_state_n     = r_state;
    w_remaining_n = r_remaining;
    w_limit_n     = r_limit;
    w_clr_n       = 1'b0;
    w_done_n      = 1'b0;
    w_restart     = 1'b0;

    // Burst progress first; a restarting command below overrides it.
    if (r_state == ST_BURST && w_tick_due && r_remaining != '0) begin
      w_remaining_n = r_remaining - COUNT_W'(1);
      if (r_remaining == COUNT_W'(1)) begin
        w_state_n = ST_IDLE;
        w_done_n  = 1'b1;
      end
    end

    if (w_accept) begin
      unique case (cmd_op)
        OP_STOP: begin
          if (r_state != ST_IDLE) begin
            w_state_n     = ST_IDLE;
            w_remaining_n = '0;
            w_done_n      = 1'b0;
            w_restart     = 1'b1;
          end
        end
        OP_RUN_FREE: begin
          w_state_n     = ST_FREE;
          w_remaining_n = '0;
          w_done_n      = 1'b0;
          w_restart     = 1'b1;
        end
        OP_RUN_N: begin
          if (cmd_arg != '0) begin
            w_state_n     = ST_BURST;
            w_remaining_n = cmd_arg;
            w_done_n      = 1'b0;
            w_clr_n       = 1'b1;
            w_restart     = 1'b1;
          end else begin
            w_done_n = 1'b1;
          end
        end
        OP_SET_LIMIT: begin
          w_limit_n = cmd_arg[PRESCALE_W-1:0];
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_remaining <= '0;
      r_limit     <= PRESCALE_W'(DEFAULT_LIMIT);
      r_clr       <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_remaining <= w_remaining_n;
      r_limit     <= w_limit_n;
      r_clr       <= w_clr_n;
      r_done      <= w_done_n;
      r_busy      <= (w_state_n != ST_IDLE);
    end
  end

  assign ctr_clr = r_clr;
  assign done    = r_done;
  assign busy    = r_busy;
  assign state   = r_state;

endmodule

`default_nettype wire

// File: tb/tb_counter_sequencer.sv
// ============================================================
// tb_counter_sequencer: directed self-checking bench for counter_sequencer
// Rev 1.0
// ============================================================
`default_nettype none

module tb_counter_sequencer;
  import counter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [23:0] cmd_arg;
  logic        ctr_inc, ctr_clr, done, busy;
  logic [1:0]  state;

  int n_vec = 0;
  int n_err = 0;

  counter_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_arg   (cmd_arg),
    .ctr_inc   (ctr_inc),
    .ctr_clr   (ctr_clr),
    .done      (done),
    .busy      (busy),
    .state     (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the command is accepted at the next posedge and
  // the task returns at the negedge following that edge.
  task automatic send(input logic [1:0] op, input logic [23:0] arg);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic observe(input int n, output int incs, output int clrs, output int dones);
    incs = 0; clrs = 0; dones = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      incs  += int'(ctr_inc);
      clrs  += int'(ctr_clr);
      dones += int'(done);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int incs, clrs, dones;
    int pos[8];
    int np, nd, dpos;

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_arg = '0;
    @(negedge clk); @(negedge clk);
    chk("rst_ready", 32'(cmd_ready), 0);
    chk("rst_outs", {27'd0, ctr_inc, ctr_clr, done, busy, 1'b0}, 0);
    chk("rst_state", 32'(state), 0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 32'(cmd_ready), 1);

    // Free run at the default limit: pulses every 1001 cycles.
    @(negedge clk);
    send(OP_RUN_FREE, 24'd0);
    chk("free_busy", 32'(busy), 1);
    chk("free_state", 32'(state), 1);
    chk("free_inc0", 32'(ctr_inc), 0);
    np = 0; clrs = int'(ctr_clr);
    for (int k = 1; k <= 3003; k++) begin
      @(negedge clk);
      if (ctr_inc) begin
        if (np < 8) pos[np] = k;
        np++;
      end
      clrs += int'(ctr_clr);
    end
    chk("free_inc_count", 32'(np), 3);
    chk("free_inc_pos0", 32'(pos[0]), 1001);
    chk("free_inc_pos1", 32'(pos[1]), 2002);
    chk("free_inc_pos2", 32'(pos[2]), 3003);
    chk("free_no_clr", 32'(clrs), 0);
    send(OP_STOP, 24'd0);
    chk("stop_state", 32'(state), 0);

    // Burst of 5 at limit 3.
    send(OP_SET_LIMIT, 24'd3);
    send(OP_RUN_N, 24'd5);
    chk("burst_clr", 32'(ctr_clr), 1);
    chk("burst_state", 32'(state), 2);
    np = 0; nd = 0; dpos = -1; clrs = 0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (ctr_inc) begin
        if (np < 8) pos[np] = k;
        np++;
      end
      if (done) begin nd++; dpos = k; end
      clrs += int'(ctr_clr);
    end
    chk("burst_inc_count", 32'(np), 5);
    chk("burst_inc_first", 32'(pos[0]), 4);
    chk("burst_inc_last", 32'(pos[4]), 20);
    chk("burst_done_count", 32'(nd), 1);
    chk("burst_done_pos", 32'(dpos), 20);
    chk("burst_clr_once", 32'(clrs), 0);
    chk("burst_end_state", 32'(state), 0);
    chk("burst_end_busy", 32'(busy), 0);

    // RUN_N 0: immediate done only.
    send(OP_RUN_N, 24'd0);
    chk("run0_done", 32'(done), 1);
    chk("run0_clr", 32'(ctr_clr), 0);
    chk("run0_state", 32'(state), 0);
    observe(5, incs, clrs, dones);
    chk("run0_quiet", 32'(incs + clrs + dones), 0);

    // Lower the limit to 0 while the prescaler sits at 700.
    send(OP_SET_LIMIT, 24'd1000);
    send(OP_RUN_FREE, 24'd0);
    observe(700, incs, clrs, dones);
    chk("lim0_pre_inc", 32'(incs), 0);
    send(OP_SET_LIMIT, 24'h01_0000);  // upper bits ignored -> limit 0
    chk("lim0_accept_inc", 32'(ctr_inc), 0);
    @(negedge clk);
    chk("lim0_wrap_inc", 32'(ctr_inc), 0);
    observe(3, incs, clrs, dones);
    chk("lim0_every_cycle", 32'(incs), 3);
    send(OP_STOP, 24'd0);
    chk("lim0_stop_inc", 32'(ctr_inc), 0);

    // STOP on the tick cycle at limit 4 suppresses that tick.
    send(OP_SET_LIMIT, 24'd4);
    send(OP_RUN_FREE, 24'd0);
    observe(4, incs, clrs, dones);
    send(OP_STOP, 24'd0);
    chk("stop_tick_inc", 32'(ctr_inc), 0);
    chk("stop_tick_state", 32'(state), 0);
    observe(6, incs, clrs, dones);
    chk("stop_tick_after", 32'(incs), 0);

    // Reset mid-burst with remaining=3.
    send(OP_RUN_N, 24'd5);
    observe(12, incs, clrs, dones);
    chk("rstb_incs", 32'(incs), 2);
    chk("rstb_dones", 32'(dones), 0);
    rst = 1'b1;
    #1;
    chk("rstb_ready", 32'(cmd_ready), 0);
    @(negedge clk);
    chk("rstb_outs", {27'd0, ctr_inc, ctr_clr, done, busy, 1'b0}, 0);
    chk("rstb_state", 32'(state), 0);
    rst = 1'b0;
    send(OP_RUN_FREE, 24'd0);
    observe(1000, incs, clrs, dones);
    chk("rstb_lim_quiet", 32'(incs), 0);
    @(negedge clk);
    chk("rstb_lim_tick", 32'(ctr_inc), 1);
    send(OP_STOP, 24'd0);

    // Continuous RUN_N 2 at limit 1 keeps restarting the burst.
    send(OP_SET_LIMIT, 24'd1);
    cmd_valid = 1'b1; cmd_op = OP_RUN_N; cmd_arg = 24'd2;
    observe(10, incs, clrs, dones);
    cmd_valid = 1'b0;
    chk("hold_clr", 32'(clrs), 10);
    chk("hold_inc", 32'(incs), 0);
    chk("hold_done", 32'(dones), 0);
    chk("hold_state", 32'(state), 2);
    send(OP_STOP, 24'd0);
    chk("hold_stop_state", 32'(state), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
